// File: rtl/hazard_stall_ctrl.sv
// Producer-side hazard detection for a 5-stage MIPS pipeline: tracks in-flight destinations/Tnew
// through E/M/W and stalls D when forwarding cannot cover an operand. Optional MDU busy stall: HAZARD_MDU_EN.
`timescale 1ns/1ps
module hazard_stall_ctrl #(
    parameter int CNT_W    = 32
`ifdef HAZARD_MDU_EN
    ,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       D_A1,
    input  logic [4:0]       D_A2,
    input  logic             D_Use_1,
    input  logic             D_Use_2,
    input  logic [1:0]       D_Tuse_1,
    input  logic [1:0]       D_Tuse_2,
    input  logic [4:0]       D_A3,
    input  logic [1:0]       D_Tnew,
`ifdef HAZARD_MDU_EN
    input  logic             D_md_start,
    input  logic             D_md_div,
    input  logic             D_md_use,
`endif
    output logic             stall,
    output logic [4:0]       E_A3,
    output logic [4:0]       M_A3,
    output logic [4:0]       W_A3,
    output logic [1:0]       E_Tnew,
    output logic [1:0]       M_Tnew,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0]       e_a3_q, e_a3_d, m_a3_q, w_a3_q;
    logic [1:0]       e_tnew_q, e_tnew_d, m_tnew_q, m_tnew_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_1, stall_2, md_stall;
    logic [1:0]       d_tnew_clamped;

    // Tnew of 3 cannot be encoded as a legal latency; a load (2) is the worst case.
    assign d_tnew_clamped = (D_Tnew == 2'd3) ? 2'd2 : D_Tnew;

`ifdef HAZARD_MDU_EN
    localparam int MD_MAX   = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int MD_W_RAW = $clog2(MD_MAX + 1);
    localparam int MD_W     = (MD_W_RAW < 4) ? 4 : MD_W_RAW;

    logic            e_md_start_q, e_md_div_q;
    logic [MD_W-1:0] md_cnt_q, md_cnt_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (e_md_start_q)
            md_cnt_d = e_md_div_q ? MD_W'(DIV_CYC) : MD_W'(MULT_CYC);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
    end

    assign md_stall = D_md_use & (e_md_start_q | (md_cnt_q != '0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            md_cnt_q     <= '0;
        end else begin
            e_md_start_q <= stall ? 1'b0 : D_md_start;
            e_md_div_q   <= stall ? 1'b0 : D_md_div;
            md_cnt_q     <= md_cnt_d;
        end
    end
`else
    assign md_stall = 1'b0;
`endif

    always_comb begin
        stall_1 = D_Use_1 && (D_A1 != 5'd0) &&
                  (((D_A1 == e_a3_q) && (D_Tuse_1 < e_tnew_q)) ||
                   ((D_A1 == m_a3_q) && (D_Tuse_1 < m_tnew_q)));
        stall_2 = D_Use_2 && (D_A2 != 5'd0) &&
                  (((D_A2 == e_a3_q) && (D_Tuse_2 < e_tnew_q)) ||
                   ((D_A2 == m_a3_q) && (D_Tuse_2 < m_tnew_q)));
        stall   = stall_1 | stall_2 | md_stall;

        // A stalled D instruction stays put; E receives a bubble instead.
        e_a3_d      = stall ? 5'd0 : D_A3;
        e_tnew_d    = stall ? 2'd0 : d_tnew_clamped;
        m_tnew_d    = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_a3_q      <= 5'd0;
            e_tnew_q    <= 2'd0;
            m_a3_q      <= 5'd0;
            m_tnew_q    <= 2'd0;
            w_a3_q      <= 5'd0;
            stall_cnt_q <= '0;
        end else begin
            e_a3_q      <= e_a3_d;
            e_tnew_q    <= e_tnew_d;
            m_a3_q      <= e_a3_q;
            m_tnew_q    <= m_tnew_d;
            w_a3_q      <= m_a3_q;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign E_A3      = e_a3_q;
    assign M_A3      = m_a3_q;
    assign W_A3      = w_a3_q;
    assign E_Tnew    = e_tnew_q;
    assign M_Tnew    = m_tnew_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed instruction-sequence table, reset corner, random stimulus
// against an instruction-history model, and MDU busy sequences when HAZARD_MDU_EN is defined.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_A1, D_A2, D_A3;
    logic        D_Use_1, D_Use_2;
    logic [1:0]  D_Tuse_1, D_Tuse_2, D_Tnew;
    logic        stall;
    logic [4:0]  E_A3, M_A3, W_A3;
    logic [1:0]  E_Tnew, M_Tnew;
    logic [31:0] stall_cnt;
`ifdef HAZARD_MDU_EN
    logic        D_md_start, D_md_div, D_md_use;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_A2(D_A2), .D_Use_1(D_Use_1), .D_Use_2(D_Use_2),
        .D_Tuse_1(D_Tuse_1), .D_Tuse_2(D_Tuse_2), .D_A3(D_A3), .D_Tnew(D_Tnew),
`ifdef HAZARD_MDU_EN
        .D_md_start(D_md_start), .D_md_div(D_md_div), .D_md_use(D_md_use),
`endif
        .stall(stall), .E_A3(E_A3), .M_A3(M_A3), .W_A3(W_A3),
        .E_Tnew(E_Tnew), .M_Tnew(M_Tnew), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [4:0] a1, a2;
        logic       u1, u2;
        logic [1:0] t1, t2;
        logic [4:0] a3;
        logic [1:0] tn;
        logic       st;
        logic [4:0] ea3;
        logic [1:0] etn;
        logic [4:0] ma3;
        logic [1:0] mtn;
        logic [4:0] wa3;
        int         cnt;
    } vec_t;

    typedef struct {
        logic [4:0] a3;
        int         tn;
    } instr_t;

    vec_t   vecs[17];
    instr_t hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [4:0] a1, input logic u1, input logic [1:0] t1,
                                 input logic [4:0] a2, input logic u2, input logic [1:0] t2,
                                 input logic [4:0] a3, input logic [1:0] tn, input logic st,
                                 input logic [4:0] ea3, input logic [1:0] etn,
                                 input logic [4:0] ma3, input logic [1:0] mtn,
                                 input logic [4:0] wa3, input int cnt);
        vec_t v;
        v.a1 = a1; v.u1 = u1; v.t1 = t1; v.a2 = a2; v.u2 = u2; v.t2 = t2;
        v.a3 = a3; v.tn = tn; v.st = st; v.ea3 = ea3; v.etn = etn;
        v.ma3 = ma3; v.mtn = mtn; v.wa3 = wa3; v.cnt = cnt;
        return v;
    endfunction

    task automatic drive_idle();
        D_A1 = 0; D_A2 = 0; D_Use_1 = 0; D_Use_2 = 0;
        D_Tuse_1 = 0; D_Tuse_2 = 0; D_A3 = 0; D_Tnew = 0;
`ifdef HAZARD_MDU_EN
        D_md_start = 0; D_md_div = 0; D_md_use = 0;
`endif
    endtask

    // Result of a producer of age n (0=E, 1=M) is ready in max(Tnew-n,0) cycles; W never stalls.
    function automatic bit model_op_stall(input logic [4:0] a, input logic u, input logic [1:0] t);
        int rem;
        for (int age = 0; age < 2; age++) begin
            rem = hist[age].tn - age;
            if (rem < 0) rem = 0;
            if (u && (a != 5'd0) && (hist[age].a3 == a) && (int'(t) < rem)) return 1'b1;
        end
        return 1'b0;
    endfunction

`ifdef HAZARD_MDU_EN
    task automatic run_md(input bit dv, input int exp_n, input string nm);
        int n;
        drive_idle();
        repeat (3) @(negedge clk);
        D_md_start = 1; D_md_div = dv; D_md_use = 1;
        #1 chk({nm, "_start_nostall"}, stall, 0);
        @(negedge clk);
        D_md_start = 0; D_md_div = 0; D_md_use = 1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!stall) break;
            n++;
            @(negedge clk);
        end
        chk({nm, "_stall_cycles"}, n, exp_n);
        $display("mdu %s: stalled %0d cycles", nm, n);
        drive_idle();
        @(negedge clk);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit          est;
        int          mcnt;
        int          exp_mtn;
        logic [1:0]  tn_c;

        //              a1 u1 t1  a2 u2 t2  a3 tn  st  ea3 etn ma3 mtn wa3 cnt
        vecs[0]  = mkv(0, 0, 0,   0, 0, 0,  8, 2,  0,  0, 0,  0, 0,  0, 0); // lw $8
        vecs[1]  = mkv(8, 1, 1,   0, 0, 0, 10, 1,  1,  8, 2,  0, 0,  0, 0); // add reads $8
        vecs[2]  = mkv(8, 1, 1,   0, 0, 0, 10, 1,  0,  0, 0,  8, 1,  0, 1);
        vecs[3]  = mkv(0, 0, 0,   0, 0, 0,  8, 2,  0, 10, 1,  0, 0,  8, 1); // lw $8
        vecs[4]  = mkv(8, 1, 0,   0, 1, 0,  0, 0,  1,  8, 2, 10, 0,  0, 1); // beq $8,$0
        vecs[5]  = mkv(8, 1, 0,   0, 1, 0,  0, 0,  1,  0, 0,  8, 1, 10, 2);
        vecs[6]  = mkv(8, 1, 0,   0, 1, 0,  0, 0,  0,  0, 0,  0, 0,  8, 3);
        vecs[7]  = mkv(0, 0, 0,   0, 0, 0,  9, 1,  0,  0, 0,  0, 0,  0, 3); // addu $9
        vecs[8]  = mkv(9, 1, 0,   0, 1, 0,  0, 0,  1,  9, 1,  0, 0,  0, 3); // beq $9,$0
        vecs[9]  = mkv(9, 1, 0,   0, 1, 0,  0, 0,  0,  0, 0,  9, 0,  0, 4);
        vecs[10] = mkv(0, 0, 0,   0, 0, 0, 11, 1,  0,  0, 0,  0, 0,  9, 4); // addu $11
        vecs[11] = mkv(11, 1, 1,  0, 0, 0, 12, 1,  0, 11, 1,  0, 0,  0, 4); // ALU-ALU
        vecs[12] = mkv(0, 0, 0,   0, 0, 0,  0, 2,  0, 12, 1, 11, 0,  0, 4); // lw $0
        vecs[13] = mkv(0, 1, 1,   0, 1, 1, 13, 1,  0,  0, 2, 12, 0, 11, 4); // addu reads $0
        vecs[14] = mkv(0, 0, 0,   0, 0, 0,  8, 2,  0, 13, 1,  0, 1, 12, 4); // lw $8
        vecs[15] = mkv(8, 0, 0,   8, 0, 0, 31, 0,  0,  8, 2, 13, 0,  0, 4); // jal, no reads
        vecs[16] = mkv(0, 0, 0,   0, 0, 0,  0, 0,  0, 31, 0,  8, 1, 13, 4);

        drive_idle();
        reset = 1;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_E_A3", E_A3, 0);
        chk("rst_M_A3", M_A3, 0);
        chk("rst_W_A3", W_A3, 0);
        chk("rst_E_Tnew", E_Tnew, 0);
        chk("rst_M_Tnew", M_Tnew, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 17; i++) begin
            D_A1 = vecs[i].a1; D_Use_1 = vecs[i].u1; D_Tuse_1 = vecs[i].t1;
            D_A2 = vecs[i].a2; D_Use_2 = vecs[i].u2; D_Tuse_2 = vecs[i].t2;
            D_A3 = vecs[i].a3; D_Tnew = vecs[i].tn;
            #1;
            chk($sformatf("vec%0d_stall", i), stall, vecs[i].st);
            chk($sformatf("vec%0d_E_A3", i), E_A3, vecs[i].ea3);
            chk($sformatf("vec%0d_E_Tnew", i), E_Tnew, vecs[i].etn);
            chk($sformatf("vec%0d_M_A3", i), M_A3, vecs[i].ma3);
            chk($sformatf("vec%0d_M_Tnew", i), M_Tnew, vecs[i].mtn);
            chk($sformatf("vec%0d_W_A3", i), W_A3, vecs[i].wa3);
            chk($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].cnt);
            $display("vec %0d: stall=%0d E=%0d/%0d M=%0d/%0d W=%0d cnt=%0d",
                     i, stall, E_A3, E_Tnew, M_A3, M_Tnew, W_A3, stall_cnt);
            @(negedge clk);
        end

        // Reset asserted in the middle of a load-use stall
        drive_idle();
        D_A3 = 8; D_Tnew = 2;
        @(negedge clk);
        drive_idle();
        D_A1 = 8; D_Use_1 = 1; D_Tuse_1 = 1; D_A3 = 10; D_Tnew = 1;
        #1 chk("midrst_pre_stall", stall, 1);
        #1 reset = 1;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_E_A3", E_A3, 0);
        chk("midrst_M_A3", M_A3, 0);
        chk("midrst_W_A3", W_A3, 0);
        chk("midrst_cnt", stall_cnt, 0);
        $display("reset mid-stall: stall=%0d cnt=%0d", stall, stall_cnt);
        @(negedge clk);
        reset = 0;
        drive_idle();

        for (int k = 0; k < 3; k++) hist.push_back('{5'd0, 0});
        mcnt = 0;
        for (int n = 0; n < 400; n++) begin
            D_A1 = 5'($urandom_range(0, 3)); D_A2 = 5'($urandom_range(0, 3));
            D_Use_1 = 1'($urandom_range(0, 1)); D_Use_2 = 1'($urandom_range(0, 1));
            D_Tuse_1 = 2'($urandom_range(0, 2)); D_Tuse_2 = 2'($urandom_range(0, 2));
            D_A3 = 5'($urandom_range(0, 3)); D_Tnew = 2'($urandom_range(0, 3));
            #1;
            est = model_op_stall(D_A1, D_Use_1, D_Tuse_1) | model_op_stall(D_A2, D_Use_2, D_Tuse_2);
            exp_mtn = (hist[1].tn > 0) ? hist[1].tn - 1 : 0;
            chk("rnd_stall", stall, est);
            chk("rnd_E_A3", E_A3, hist[0].a3);
            chk("rnd_E_Tnew", E_Tnew, hist[0].tn);
            chk("rnd_M_A3", M_A3, hist[1].a3);
            chk("rnd_M_Tnew", M_Tnew, exp_mtn);
            chk("rnd_W_A3", W_A3, hist[2].a3);
            chk("rnd_cnt", stall_cnt, mcnt);
            $display("rnd %0d: A1=%0d A2=%0d A3=%0d Tnew=%0d stall=%0d", n, D_A1, D_A2, D_A3, D_Tnew, stall);
            tn_c = (D_Tnew == 2'd3) ? 2'd2 : D_Tnew;
            if (est) hist.push_front('{5'd0, 0});
            else     hist.push_front('{D_A3, int'(tn_c)});
            void'(hist.pop_back());
            mcnt += int'(est);
            @(negedge clk);
        end
        drive_idle();

`ifdef HAZARD_MDU_EN
        run_md(1'b0, 6, "mult");
        run_md(1'b1, 11, "div");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
